// File: rtl/row_pp_pkg.sv
// Shared row post-processing definitions: lane width, default lane count,
// the packed row type and a lane slice helper.
package row_pp_pkg;

  localparam int FP16_W      = 16;
  localparam int COL_NUM_DEF = 32;

  typedef logic [FP16_W-1:0]             fp16_t;
  typedef logic [COL_NUM_DEF*FP16_W-1:0] row_t;

  // Lane c of a packed row; lane 0 sits in the least significant bits.
  function automatic fp16_t lane_of(input row_t r, input int c);
    return r[c*FP16_W +: FP16_W];
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous show-ahead FIFO: rdata is always the head entry, and a push
// against a full FIFO is accepted only when a pop happens in the same cycle.
module row_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is reset as well, because rdata drives a top-level output
  // that must read 0 after reset or clear; the pointers alone would not do it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fp16_diag_deskew.sv
// Re-aligns a diagonally skewed FP16 lane stream into whole rows and presents
// them one per valid/ready handshake with a row index and tile-last marker.
module fp16_diag_deskew
  import row_pp_pkg::*;
#(
  parameter int COL_NUM       = COL_NUM_DEF,
  parameter int BIT_WIDTH     = FP16_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROWS_PER_TILE = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             soft_clr,
  input  logic [COL_NUM*BIT_WIDTH-1:0]     fp16_in_diagonal,
  input  logic                             fp16_valid_diagonal,
  output logic [COL_NUM*BIT_WIDTH-1:0]     row_data,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [$clog2(ROWS_PER_TILE)-1:0] row_idx,
  output logic                             tile_last,
  output logic                             overflow
);

  localparam int                 IDX_W    = $clog2(ROWS_PER_TILE);
  localparam int                 ROW_W    = COL_NUM*BIT_WIDTH;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ROWS_PER_TILE-1);

  logic [COL_NUM-1:1] lane_vld;
  logic [ROW_W-1:0]   aligned;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [IDX_W-1:0]   row_cnt;

  // lane_vld[k] is the row-start valid delayed k cycles; the top stage marks
  // the edge on which every lane of that row is aligned.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_vld <= '0;
    end else if (soft_clr) begin
      lane_vld <= '0;
    end else begin
      lane_vld[1] <= fp16_valid_diagonal;
      for (int k = 2; k < COL_NUM; k++) lane_vld[k] <= lane_vld[k-1];
    end
  end

  for (genvar c = 0; c < COL_NUM; c++) begin : g_lane
    if (c == COL_NUM-1) begin : g_last
      assign aligned[c*BIT_WIDTH +: BIT_WIDTH] = fp16_in_diagonal[c*BIT_WIDTH +: BIT_WIDTH];
    end else begin : g_dly
      localparam int D = COL_NUM-1-c;
      logic [BIT_WIDTH-1:0] dly [D];

      // NOTE: pure data delay line, deliberately without reset; stale contents
      // are never pushed because the lane valid pipe is what gets cleared.
      always_ff @(posedge clk) begin
        dly[0] <= fp16_in_diagonal[c*BIT_WIDTH +: BIT_WIDTH];
        for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
      end

      assign aligned[c*BIT_WIDTH +: BIT_WIDTH] = dly[D-1];
    end
  end

  assign push      = lane_vld[COL_NUM-1] && !soft_clr;
  assign pop       = row_valid && row_ready;
  assign row_valid = !empty;
  assign row_idx   = row_cnt;
  assign tile_last = row_valid && (row_cnt == LAST_IDX);

  row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_clr),
    .push  (push),
    .pop   (pop),
    .wdata (aligned),
    .rdata (row_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else if (soft_clr) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + IDX_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp16_diag_deskew.sv
// Randomized bench for fp16_diag_deskew: rows are modelled as whole vectors
// keyed by their start cycle and tracked through a queue-based FIFO model.
module tb_fp16_diag_deskew;
  import row_pp_pkg::*;

  localparam int COLS  = COL_NUM_DEF;
  localparam int BW    = FP16_W;
  localparam int DEPTH = 4;
  localparam int RPT   = 4;
  localparam int ROW_W = COLS*BW;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    soft_clr = 1'b0;
  logic [ROW_W-1:0]        fp16_in_diagonal = '0;
  logic                    fp16_valid_diagonal = 1'b0;
  logic [ROW_W-1:0]        row_data;
  logic                    row_valid;
  logic                    row_ready = 1'b0;
  logic [$clog2(RPT)-1:0]  row_idx;
  logic                    tile_last;
  logic                    overflow;

  always #5 clk = ~clk;

  fp16_diag_deskew #(
    .COL_NUM       (COLS),
    .BIT_WIDTH     (BW),
    .FIFO_DEPTH    (DEPTH),
    .ROWS_PER_TILE (RPT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .soft_clr            (soft_clr),
    .fp16_in_diagonal    (fp16_in_diagonal),
    .fp16_valid_diagonal (fp16_valid_diagonal),
    .row_data            (row_data),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .row_idx             (row_idx),
    .tile_last           (tile_last),
    .overflow            (overflow)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  row_t row_at [int];
  bit   live   [int];
  row_t q [$];
  int   m_idx = 0;
  bit   m_ovf = 1'b0;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic add_row(input int off, input row_t r);
    row_at[cyc+off] = r;
    live[cyc+off]   = 1'b1;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < ROW_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic row_t pat_row(input int r);
    row_t v;
    for (int c = 0; c < COLS; c++) v[c*BW +: BW] = {8'(r), 8'(c)};
    return v;
  endfunction

  // One clock: drive lanes for the edge, update the model at the edge, check at negedge.
  task automatic step(input bit rdy, input bit do_rst = 1'b0, input bit do_clr = 1'b0);
    row_t lanes;
    bit   pop;
    int   done_start;
    for (int c = 0; c < COLS; c++)
      lanes[c*BW +: BW] = row_at.exists(cyc-c) ? lane_of(row_at[cyc-c], c) : BW'($urandom);
    fp16_in_diagonal    = lanes;
    fp16_valid_diagonal = row_at.exists(cyc);
    row_ready           = rdy;
    soft_clr            = do_clr;
    rst_n               = !do_rst;
    @(posedge clk);
    done_start = cyc - (COLS-1);
    if (do_rst || do_clr) begin
      q.delete();
      m_idx = 0;
      m_ovf = 1'b0;
      live.delete();
    end else begin
      pop = (q.size() > 0) && rdy;
      if (pop) begin
        void'(q.pop_front());
        m_idx = (m_idx + 1) % RPT;
      end
      if (live.exists(done_start)) begin
        if (q.size() < DEPTH) q.push_back(row_at[done_start]);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    check("row_valid", ROW_W'(row_valid), ROW_W'(q.size() > 0));
    check("overflow", ROW_W'(overflow), ROW_W'(m_ovf));
    if (q.size() > 0) begin
      check("row_data", row_data, q[0]);
      check("row_idx", ROW_W'(row_idx), ROW_W'(m_idx));
      check("tile_last", ROW_W'(tile_last), ROW_W'(m_idx == RPT-1));
    end else begin
      check("tile_last_idle", ROW_W'(tile_last), '0);
      if (do_rst || do_clr) begin
        check("row_data_clr", row_data, '0);
        check("row_idx_clr", ROW_W'(row_idx), '0);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy);
  endtask

  initial begin
    row_t r;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Single row, lane c = 3C00+c.
    for (int c = 0; c < COLS; c++) r[c*BW +: BW] = 16'h3C00 + 16'(c);
    add_row(2, r);
    run(40, 1'b1);

    // Ten back-to-back rows.
    for (int i = 0; i < 10; i++) add_row(i, pat_row(i));
    run(45, 1'b1);

    // Five rows into a stalled FIFO, then drain.
    for (int i = 0; i < 5; i++) add_row(i, pat_row(16 + i));
    run(40, 1'b0);
    run(10, 1'b1);

    // Reset at E0+10 of a row, then a clean row.
    add_row(1, rand_row());
    run(11, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    add_row(1, pat_row(40));
    run(40, 1'b1);

    // Tile indexing over eight rows.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) add_row(i, pat_row(64 + i));
    run(45, 1'b1);

    // Soft clear mid-row discards the row.
    add_row(0, rand_row());
    run(15, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(40, 1'b1);

    // Full FIFO with ready toggling while rows stream.
    for (int i = 0; i < 24; i++) add_row(i, pat_row(128 + i));
    run(34, 1'b0);
    for (int i = 0; i < 24; i++) step(i[0]);
    run(20, 1'b1);

    // Random traffic and backpressure.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) add_row(0, rand_row());
      step(1'($urandom_range(0, 1)));
    end
    run(45, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
